// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the single-port 32K x 16 distributed memory.
// Round-robin ownership with a hold limit, per-port lock and registered read return.
module mem_port_arbiter #(
    parameter int AW       = 15,
    parameter int DW       = 16,
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] adrs0,
    input  logic [DW-1:0] wdata0,
    input  logic          lock0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] adrs1,
    input  logic [DW-1:0] wdata1,
    input  logic          lock1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo
);

    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t        state;
    logic          last;
    logic [HW-1:0] hold;
    logic          sat;
    logic          acc0;
    logic          acc1;

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign acc0 = gnt0 && req0;
    assign acc1 = gnt1 && req1;
    assign sat  = (hold == HOLD_MAX);

    // Ownership FSM: round-robin pick from IDLE, handover, forced rotation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            last  <= 1'b1;
            hold  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        hold  <= '0;
                    end else if (req1) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        hold  <= '0;
                    end
                end
                OWN0: begin
                    if (req1 && (!req0 || (!lock0 && sat))) begin
                        state <= OWN1;
                        last  <= 1'b1;
                        hold  <= '0;
                    end else if (!req0) begin
                        state <= IDLE;
                        hold  <= '0;
                    end else if (!sat) begin
                        hold <= hold + 1'b1;
                    end
                end
                OWN1: begin
                    if (req0 && (!req1 || (!lock1 && sat))) begin
                        state <= OWN0;
                        last  <= 1'b0;
                        hold  <= '0;
                    end else if (!req1) begin
                        state <= IDLE;
                        hold  <= '0;
                    end else if (!sat) begin
                        hold <= hold + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    hold  <= '0;
                end
            endcase
        end
    end

    // Memory mux; strobe is gated by reset so a write aborts instantly.
    always_comb begin
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        case (state)
            OWN0: begin
                mem_a  = adrs0;
                mem_d  = wdata0;
                mem_we = rst && req0 && we0;
            end
            OWN1: begin
                mem_a  = adrs1;
                mem_d  = wdata1;
                mem_we = rst && req1 && we1;
            end
            default: begin
                mem_a  = '0;
                mem_d  = '0;
                mem_we = 1'b0;
            end
        endcase
    end

    // Capture read data for the port whose read was accepted this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= acc0 && !we0;
            rvalid1 <= acc1 && !we1;
            if (acc0 && !we0) begin
                rdata0 <= mem_spo;
            end
            if (acc1 && !we1) begin
                rdata1 <= mem_spo;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a read-return scoreboard.
// Memory model returns a per-address pattern until a word is written.
module tb_mem_port_arbiter;

    localparam int AW = 15;
    localparam int DW = 16;
    localparam int MH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, we0 = 1'b0, lock0 = 1'b0;
    logic          req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [AW-1:0] adrs0 = '0, adrs1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, mem_we;
    logic [DW-1:0] rdata0, rdata1, mem_d, mem_spo;
    logic [AW-1:0] mem_a;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(MH)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .adrs0(adrs0), .wdata0(wdata0),
        .lock0(lock0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .adrs1(adrs1), .wdata1(wdata1),
        .lock1(lock1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return DW'(a) ^ 16'hA5A5;
    endfunction

    // Memory model
    bit [DW-1:0] mem [0:(1<<AW)-1];
    bit          wr  [0:(1<<AW)-1];
    assign mem_spo = wr[mem_a] ? mem[mem_a] : pat(mem_a);
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_a] <= mem_d;
            wr[mem_a]  <= 1'b1;
        end
    end

    // Reference contents, updated from the bench's own view of accepted writes
    bit [DW-1:0] ref_mem [0:(1<<AW)-1];
    bit          ref_wr  [0:(1<<AW)-1];
    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_wr[a] ? ref_mem[a] : pat(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: push expected read data at accept, pop on rvalid
    logic [DW-1:0] q0[$], q1[$];
    logic          pend0 = 1'b0, pend1 = 1'b0;
    logic [DW-1:0] er0 = '0, er1 = '0;

    always @(negedge clk) begin
        if (!rst) begin
            pend0 = 1'b0;
            pend1 = 1'b0;
            er0   = '0;
            er1   = '0;
            q0.delete();
            q1.delete();
        end else begin
            chk("sb_rvalid0", rvalid0, pend0);
            chk("sb_rvalid1", rvalid1, pend1);
            if (pend0) begin
                chk("sb_q0_nonempty", q0.size() > 0, 1);
                if (q0.size() > 0) er0 = q0.pop_front();
            end
            if (pend1) begin
                chk("sb_q1_nonempty", q1.size() > 0, 1);
                if (q1.size() > 0) er1 = q1.pop_front();
            end
            chk("sb_rdata0", rdata0, er0);
            chk("sb_rdata1", rdata1, er1);
            pend0 = gnt0 && req0 && !we0;
            pend1 = gnt1 && req1 && !we1;
            if (pend0) q0.push_back(ref_rd(adrs0));
            if (pend1) q1.push_back(ref_rd(adrs1));
            if (gnt0 && req0 && we0) begin
                ref_mem[adrs0] = wdata0;
                ref_wr[adrs0]  = 1'b1;
            end
            if (gnt1 && req1 && we1) begin
                ref_mem[adrs1] = wdata1;
                ref_wr[adrs1]  = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic eg0, eg1, g0, g1;

        // Reset state
        #1;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_mem_we", mem_we, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();

        // Solo write then read on port 0
        req0 = 1'b1; we0 = 1'b1; adrs0 = 15'h0005; wdata0 = 16'h1234;
        @(negedge clk);
        chk("b_gnt0_lat", gnt0, 0);
        tick();
        @(negedge clk);
        chk("b_gnt0", gnt0, 1);
        chk("b_mem_we", mem_we, 1);
        chk("b_mem_a", mem_a, 15'h0005);
        chk("b_mem_d", mem_d, 16'h1234);
        tick();
        we0 = 1'b0;
        @(negedge clk);
        chk("b_rd_mem_we", mem_we, 0);
        chk("b_rd_gnt0", gnt0, 1);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("b_rvalid0", rvalid0, 1);
        chk("b_rdata0", rdata0, 16'h1234);
        tick();

        // Port 1 reads the same word, leaving last = 1
        req1 = 1'b1; we1 = 1'b0; adrs1 = 15'h0005;
        tick();
        @(negedge clk);
        chk("c_gnt1", gnt1, 1);
        chk("c_mem_a", mem_a, 15'h0005);
        tick();
        req1 = 1'b0;
        @(negedge clk);
        chk("c_rvalid1", rvalid1, 1);
        chk("c_rdata1", rdata1, 16'h1234);
        tick();

        // Tie after port 1 service, then fair rotation every MH accepts
        req0 = 1'b1; we0 = 1'b0; adrs0 = 15'h0100;
        req1 = 1'b1; we1 = 1'b0; adrs1 = 15'h0200;
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            eg0 = (k >= 1 && k <= 4) || (k >= 9);
            eg1 = (k >= 5 && k <= 8);
            g0 = gnt0;
            g1 = gnt1;
            chk($sformatf("d_gnt0_%0d", k), gnt0, eg0);
            chk($sformatf("d_gnt1_%0d", k), gnt1, eg1);
            tick();
            if (g0) adrs0 = adrs0 + 1'b1;
            if (g1) adrs1 = adrs1 + 1'b1;
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Lock holds ownership past the hold limit
        req0 = 1'b1; lock0 = 1'b1; we0 = 1'b0; adrs0 = 15'h0300;
        tick();
        req1 = 1'b1; we1 = 1'b0; adrs1 = 15'h0400;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk($sformatf("e_gnt0_%0d", i), gnt0, 1);
            chk($sformatf("e_gnt1_%0d", i), gnt1, 0);
            tick();
            adrs0 = adrs0 + 1'b1;
        end
        lock0 = 1'b0;
        @(negedge clk);
        chk("e_unlock_gnt0", gnt0, 1);
        tick();
        @(negedge clk);
        chk("e_rot_gnt1", gnt1, 1);
        chk("e_rot_gnt0", gnt0, 0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Handover when the owner drops its request
        req0 = 1'b1; we0 = 1'b1; adrs0 = 15'h0010; wdata0 = 16'hBEEF;
        tick();
        req1 = 1'b1; we1 = 1'b0; adrs1 = 15'h0010;
        @(negedge clk);
        chk("f_gnt0", gnt0, 1);
        chk("f_mem_we", mem_we, 1);
        chk("f_mem_d", mem_d, 16'hBEEF);
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("f_drop_gnt0", gnt0, 1);
        chk("f_drop_mem_we", mem_we, 0);
        chk("f_drop_rvalid0", rvalid0, 0);
        tick();
        @(negedge clk);
        chk("f_ho_gnt1", gnt1, 1);
        chk("f_ho_gnt0", gnt0, 0);
        chk("f_ho_rvalid0", rvalid0, 0);
        chk("f_ho_mem_a", mem_a, 15'h0010);
        tick();
        req1 = 1'b0;
        @(negedge clk);
        chk("f_rvalid1", rvalid1, 1);
        chk("f_rdata1", rdata1, 16'hBEEF);
        tick();

        // Asynchronous reset in the middle of a write cycle
        req0 = 1'b1; we0 = 1'b1; adrs0 = 15'h0020; wdata0 = 16'h5555;
        req1 = 1'b1; we1 = 1'b1; adrs1 = 15'h0021; wdata1 = 16'h6666;
        @(negedge clk);
        chk("g_idle_gnt0", gnt0, 0);
        tick();
        #2;
        chk("g_pre_gnt0", gnt0, 1);
        chk("g_pre_mem_we", mem_we, 1);
        rst = 1'b0;
        #1;
        chk("g_rst_gnt0", gnt0, 0);
        chk("g_rst_gnt1", gnt1, 0);
        chk("g_rst_mem_we", mem_we, 0);
        chk("g_rst_rvalid0", rvalid0, 0);
        chk("g_rst_rvalid1", rvalid1, 0);
        chk("g_rst_rdata0", rdata0, 0);
        chk("g_rst_rdata1", rdata1, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("g_rel_gnt0", gnt0, 0);
        tick();
        @(negedge clk);
        chk("g_after_gnt0", gnt0, 1);
        chk("g_after_mem_we", mem_we, 1);
        chk("g_after_mem_a", mem_a, 15'h0020);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Read back the word written after reset
        req0 = 1'b1; we0 = 1'b0; adrs0 = 15'h0020;
        tick();
        tick();
        req0 = 1'b0;
        @(negedge clk);
        chk("g_rb_rvalid0", rvalid0, 1);
        chk("g_rb_rdata0", rdata0, 16'h5555);
        tick();
        tick();
        chk("q_drain", q0.size() + q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
